// File: rtl/count_run_sequencer.sv
// count_run_sequencer: launches a programmable batch of counting runs on a
// 4-bit go/counter/done_sig engine. Each run is checked against the engine
// protocol. A protocol violation or a timeout latches a fault code, which is
// held until clear.
module count_run_sequencer #(
    parameter int CNT_W   = 4,
    parameter int RUN_W   = 8,
    parameter int TIMEOUT = 32,
    parameter int GAP     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RUN_W-1:0] runs,
    input  logic             clear,
    input  logic [CNT_W-1:0] counter,
    input  logic             done_sig,
    output logic             go,
    output logic             busy,
    output logic [RUN_W-1:0] run_count,
    output logic             all_done,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_FAULT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_TIMEOUT  = 2'd1,
        FC_SEQUENCE = 2'd2,
        FC_SPURIOUS = 2'd3
    } fault_code_e;

    state_e      state_q,      state_d;
    fault_code_e fault_code_q, fault_code_d;
    logic [RUN_W-1:0] remaining_q, remaining_d;
    logic [RUN_W-1:0] run_count_q, run_count_d;
    logic [TMR_W-1:0] timer_q,     timer_d;
    logic [CNT_W-1:0] prev_q,      prev_d;
    logic [GAP_W-1:0] gap_q,       gap_d;
    logic             started_q,   started_d;
    logic             all_done_q,  all_done_d;

    logic seq_ok;
    logic run_valid;
    logic run_count_inc_sat;

    // Counter check: 0 may be held before the first step, and that step must
    // land on 1. After it, the counter either holds or advances by one
    // (mod 2^CNT_W).
    assign seq_ok = started_q ? ((counter == prev_q) || (counter == prev_q + CNT_ONE))
                              : ((counter == '0) || (counter == CNT_ONE));

    // A run is complete only when done arrives on the wrap from all-ones to 0.
    assign run_valid = started_q && (counter == '0) && (prev_q == CNT_MAX);

    assign run_count_inc_sat = ~(&run_count_q);

    // Next-state and register-update logic for the batch FSM.
    always_comb begin
        // NOTE: every signal driven here receives a default first, so that no
        // path through the case statement can leave a latch behind.
        state_d      = state_q;
        fault_code_d = fault_code_q;
        remaining_d  = remaining_q;
        run_count_d  = run_count_q;
        timer_d      = timer_q;
        prev_d       = prev_q;
        gap_d        = gap_q;
        started_d    = started_q;
        all_done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (done_sig) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_SPURIOUS;
                end else if (start) begin
                    run_count_d = '0;
                    if (runs != '0) begin
                        remaining_d = runs;
                        state_d     = ST_ISSUE;
                    end else begin
                        all_done_d = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                timer_d   = '0;
                prev_d    = '0;
                started_d = 1'b0;
                if (done_sig) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_SPURIOUS;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                timer_d = timer_q + TMR_ONE;
                prev_d  = counter;
                if (done_sig) begin
                    if (run_valid) begin
                        if (run_count_inc_sat) begin
                            run_count_d = run_count_q + RUN_ONE;
                        end
                        remaining_d = remaining_q - RUN_ONE;
                        if (remaining_q == RUN_ONE) begin
                            all_done_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            gap_d   = '0;
                            state_d = ST_GAP;
                        end
                    end else begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_SEQUENCE;
                    end
                end else if (!seq_ok) begin
                    // A sequence violation outranks a simultaneous timeout.
                    state_d      = ST_FAULT;
                    fault_code_d = FC_SEQUENCE;
                end else if (timer_q == TMR_LAST) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end else begin
                    started_d = started_q | (counter != '0);
                end
            end

            ST_GAP: begin
                if (done_sig) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_SPURIOUS;
                end else if (gap_q == GAP_LAST) begin
                    state_d = ST_ISSUE;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            ST_FAULT: begin
                if (clear) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FC_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments, so
        // every register samples the values from before the edge.
        if (rst) begin
            state_q      <= ST_IDLE;
            fault_code_q <= FC_NONE;
            remaining_q  <= '0;
            run_count_q  <= '0;
            timer_q      <= '0;
            prev_q       <= '0;
            gap_q        <= '0;
            started_q    <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            remaining_q  <= remaining_d;
            run_count_q  <= run_count_d;
            timer_q      <= timer_d;
            prev_q       <= prev_d;
            gap_q        <= gap_d;
            started_q    <= started_d;
            all_done_q   <= all_done_d;
        end
    end

    // go is gated by rst so that a reset can never coincide with a launch.
    assign go         = (state_q == ST_ISSUE) && !rst;
    assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_GAP);
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fault_code_q;
    assign run_count  = run_count_q;
    assign all_done   = all_done_q;

endmodule

// File: doc/count_run_sequencer.md
# count_run_sequencer

Initiator for the 4-bit go/counter/done_sig counting engine. On a `start` request it issues a programmable number of back-to-back counting runs by pulsing `go`. It watches `counter` and `done_sig` to check every run against the engine protocol, counts completed runs, and latches a fault code on any protocol violation or timeout. It sits between control logic and one counting engine, with its `go` wired to the engine's `go` and the engine's `counter`/`done_sig` wired back to it.

## Interface
- `CNT_W`, 4: width of the monitored `counter`; the engine wraps at 2^CNT_W.
- `RUN_W`, 8: width of `runs` and `run_count`.
- `TIMEOUT`, 32: maximum cycles from `go` to `done_sig` before a timeout fault; must be ≥ 2^CNT_W + 2.
- `GAP`, 1: idle cycles inserted after each `done_sig` before the next `go`; must be ≥ 1.

Ports:
- `clk`, in, 1: single clock, all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a batch; sampled only in IDLE.
- `runs`, in, RUN_W: number of runs in the batch; captured with `start`.
- `clear`, in, 1: leave FAULT; ignored in other states.
- `counter`, in, CNT_W: engine count value.
- `done_sig`, in, 1: engine completion flag.
- `go`, out, 1: one-cycle launch pulse to the engine.
- `busy`, out, 1: high in every state except IDLE and FAULT.
- `run_count`, out, RUN_W: runs completed in the current or last batch.
- `all_done`, out, 1: one-cycle pulse when the batch completes.
- `fault`, out, 1: high while in FAULT.
- `fault_code`, out, 2: 0 none, 1 timeout, 2 sequence error, 3 spurious done.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT, GAP and FAULT. Reset enters IDLE.
- Reset values: `go`=0, `busy`=0, `run_count`=0, `all_done`=0, `fault`=0, `fault_code`=0. All internal registers (remaining runs, timer, previous counter, gap counter) are cleared.
- IDLE:
  - `start`=1 with `runs`≠0: latch `runs`, clear `run_count`, go to ISSUE.
  - `start`=1 with `runs`=0: pulse `all_done` next cycle, clear `run_count`, stay in IDLE.
- ISSUE: `go`=1 for exactly this cycle. Clear the timer and previous-counter registers. Go to WAIT.
- WAIT: the timer increments every cycle. Counter check:
  - `counter` may hold 0 until the first nonzero value.
  - The first nonzero value must be 1.
  - After that, each cycle `counter` must equal previous+1 (mod 2^CNT_W) or hold its previous value. A hold counts against the timeout.
- WAIT exits:
  - `done_sig`=1 with `counter`=0 and previous value 2^CNT_W−1: the run is valid. Increment `run_count`. If it was the last run, pulse `all_done` and go to IDLE; otherwise go to GAP.
  - `done_sig`=1 with any other counter history: sequence error, code 2.
  - Any counter-check violation: code 2.
  - Timer reaching TIMEOUT before a valid done: code 1.
- GAP: wait GAP cycles, then go to ISSUE. `done_sig`=1 in GAP gives code 3.
- `done_sig`=1 in IDLE or ISSUE gives code 3.
- FAULT:
  - `fault`=1 and `fault_code` hold, and `run_count` freezes.
  - `start` is ignored.
  - `clear`=1 returns to IDLE with `fault_code`=0 and `run_count` unchanged.
- Fault priority in the same cycle: sequence (2) > timeout (1).
- `rst` asserted mid-batch returns to IDLE on the next edge. `go` is never asserted on that cycle.

## Timing
- `start` sampled at edge E0 → `go` high E0–E1 → WAIT from E1.
- With a conforming engine, `counter`=1 after E2 and 15 after E16. `done_sig`=1 and `counter`=0 during E17–E18.
- The sequencer samples done at E18. `run_count` updates at E18. `all_done` is high E18–E19 for the final run. With GAP=1, the next `go` is high E19–E20.
- Per-run period with GAP=1: 19 cycles. A batch of N runs finishes N·19−1 cycles after E0.
- `all_done` and the `run_count` update occur on the same edge. `go` and `all_done` are never high together.
- `run_count` saturates at 2^RUN_W−1; it cannot exceed `runs`.

## Test plan
- runs=1 with a conforming engine model: `go` high for one cycle after `start`; `run_count`=1 and `all_done` pulse 18 cycles after `start`; `fault`=0.
- runs=3, GAP=1: exactly 3 `go` pulses spaced 19 cycles apart; `run_count` steps 1,2,3; a single `all_done`; `busy` drops with `all_done`.
- Engine skips from 5 to 7: `fault`=1, `fault_code`=2 on the edge after 7 is sampled; `run_count` holds 0. Then `clear` → IDLE with `fault_code`=0.
- Engine ignores `go` (counter stays 0), TIMEOUT=32: `fault_code`=1 exactly 32 cycles after WAIT entry; no further `go`.
- `done_sig` pulsed while in IDLE → `fault_code`=3. `rst` mid-WAIT of run 2 of 4 → next cycle all outputs are at reset values and `go` stays 0.
- `start` with runs=0 → `all_done` pulse one cycle later, `go` never asserted, `run_count`=0.
